// File: rtl/nco_sine_gen.sv
// Numerically-controlled sine oscillator: phase accumulator, quarter-wave ROM,
// and a 3-stage pipeline (address/gain, ROM read, negate/shift) with a valid strobe.
module nco_sine_gen #(
  parameter int unsigned        PHASE_W    = 32,
  parameter int unsigned        LUT_ADDR_W = 8,
  parameter int unsigned        AMP_W      = 8,
  parameter logic [PHASE_W-1:0] INIT_INCR  = 32'h0962_FC96
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       step_in,
  input  logic                       incr_load_in,
  input  logic [PHASE_W-1:0]         incr_in,
  input  logic                       sync_in,
  input  logic [$clog2(AMP_W)-1:0]   gain_in,
  output logic [AMP_W-1:0]           amp_out,
  output logic                       amp_valid_out,
  output logic [PHASE_W-1:0]         phase_out
);

  localparam int unsigned GAIN_W = $clog2(AMP_W);
  localparam int unsigned K_W    = LUT_ADDR_W - 2;
  localparam int unsigned QN     = 1 << K_W;
  localparam int unsigned MAG_W  = AMP_W - 1;
  localparam longint      PI_Q32 = 64'sh3_243F_6A88;

  // Integer Taylor series in Q30 so the table is built at elaboration without real math.
  function automatic logic [QN*MAG_W-1:0] gen_qtab();
    longint x, x2, term, s, amp, mag;
    logic [QN*MAG_W-1:0] tab;
    tab = '0;
    amp = (longint'(1) << (AMP_W - 1)) - 1;
    for (int unsigned k = 0; k < QN; k++) begin
      x    = (longint'(2 * k + 1) * PI_Q32) >>> (LUT_ADDR_W + 2);
      x2   = (x * x) >>> 30;
      term = x;
      s    = x;
      for (int unsigned n = 1; n <= 6; n++) begin
        term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
        s    = s + term;
      end
      mag = (amp * s + (longint'(1) << 29)) >>> 30;
      tab[k*MAG_W +: MAG_W] = mag[MAG_W-1:0];
    end
    return tab;
  endfunction

  localparam logic [QN*MAG_W-1:0] QTAB = gen_qtab();

  logic [PHASE_W-1:0]    r_phase;
  logic [PHASE_W-1:0]    r_incr;
  logic                  r_s1_valid;
  logic [LUT_ADDR_W-1:0] r_s1_addr;
  logic [GAIN_W-1:0]     r_s1_gain;
  logic                  r_s2_valid;
  logic                  r_s2_neg;
  logic [MAG_W-1:0]      r_s2_mag;
  logic [GAIN_W-1:0]     r_s2_gain;
  logic                  r_valid;
  logic [AMP_W-1:0]      r_amp;

  logic [LUT_ADDR_W-1:0] w_addr;
  logic [K_W-1:0]        w_k;
  logic [AMP_W-1:0]      w_mag_ext;
  logic [AMP_W-1:0]      w_sample;

  assign w_addr    = sync_in ? '0 : r_phase[PHASE_W-1 -: LUT_ADDR_W];
  assign w_k       = r_s1_addr[K_W-1:0] ^ {K_W{r_s1_addr[LUT_ADDR_W-2]}};
  assign w_mag_ext = {1'b0, r_s2_mag};
  assign w_sample  = r_s2_neg ? ('0 - w_mag_ext) : w_mag_ext;

  // Sync with a step restarts from phase 0, so the next phase is one (old) increment on.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_phase <= '0;
      r_incr  <= INIT_INCR;
    end else begin
      if (sync_in) r_phase <= step_in ? r_incr : '0;
      else if (step_in) r_phase <= r_phase + r_incr;
      if (incr_load_in) r_incr <= incr_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_gain  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_neg   <= 1'b0;
      r_s2_mag   <= '0;
      r_s2_gain  <= '0;
      r_valid    <= 1'b0;
      r_amp      <= '0;
    end else begin
      r_s1_valid <= step_in;
      if (step_in) begin
        r_s1_addr <= w_addr;
        r_s1_gain <= gain_in;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mag  <= QTAB[int'(w_k)*MAG_W +: MAG_W];
        r_s2_neg  <= r_s1_addr[LUT_ADDR_W-1];
        r_s2_gain <= r_s1_gain;
      end
      r_valid <= r_s2_valid;
      if (r_s2_valid) r_amp <= $signed(w_sample) >>> r_s2_gain;
    end
  end

  assign amp_out       = r_amp;
  assign amp_valid_out = r_valid;
  assign phase_out     = r_phase;

endmodule

// File: tb/tb_nco_sine_gen.sv
// Directed bench for nco_sine_gen: spaced steps, gain, negative wrap,
// back-to-back throughput with increment reload, sync, and mid-stream reset.
module tb_nco_sine_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step;
  logic        incr_load;
  logic [31:0] incr;
  logic        sync;
  logic [2:0]  gain;
  logic [7:0]  amp;
  logic        valid;
  logic [31:0] phase;

  int errors = 0;
  int checks = 0;

  logic signed [7:0] exp1 [8]  = '{8'sd2, 8'sd127, -8'sd2, -8'sd127, 8'sd2, 8'sd127, -8'sd2, -8'sd127};
  logic signed [7:0] exp2 [8]  = '{8'sd1, 8'sd63, -8'sd1, -8'sd64, 8'sd1, 8'sd63, -8'sd1, -8'sd64};
  logic signed [7:0] exp3 [4]  = '{8'sd2, -8'sd127, -8'sd2, 8'sd127};
  logic [31:0]       ph3  [4]  = '{32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
  logic signed [7:0] exp4 [16] = '{8'sd2, 8'sd127, -8'sd2, -8'sd127, 8'sd2, 8'sd127, -8'sd2, -8'sd127,
                                   8'sd2, -8'sd2, 8'sd2, -8'sd2, 8'sd2, -8'sd2, 8'sd2, -8'sd2};
  logic signed [7:0] exp5 [3]  = '{8'sd2, 8'sd127, -8'sd2};
  logic [31:0]       ph5  [3]  = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000};

  nco_sine_gen #(
    .PHASE_W    (32),
    .LUT_ADDR_W (8),
    .AMP_W      (8),
    .INIT_INCR  (32'h0962_FC96)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .step_in       (step),
    .incr_load_in  (incr_load),
    .incr_in       (incr),
    .sync_in       (sync),
    .gain_in       (gain),
    .amp_out       (amp),
    .amp_valid_out (valid),
    .phase_out     (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One step followed by three idle cycles; checks latency, value and hold.
  task automatic spaced_step(input string tag, input logic signed [7:0] e_amp,
                             input logic [31:0] e_ph, input logic [2:0] g, input logic s);
    step = 1'b1; gain = g; sync = s;
    @(negedge clk);
    step = 1'b0; gain = '0; sync = 1'b0;
    chk({tag, "_phase"}, phase, e_ph);
    chk({tag, "_v_c1"}, {31'b0, valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_v_c2"}, {31'b0, valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_v_c3"}, {31'b0, valid}, 32'd1);
    chk({tag, "_amp"}, {24'b0, amp}, {24'b0, e_amp});
    @(negedge clk);
    chk({tag, "_v_c4"}, {31'b0, valid}, 32'd0);
    chk({tag, "_hold"}, {24'b0, amp}, {24'b0, e_amp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; step = 1'b0; incr_load = 1'b0; incr = '0; sync = 1'b0; gain = '0;
    repeat (2) @(negedge clk);
    chk("rst_phase", phase, 32'd0);
    chk("rst_amp", {24'b0, amp}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    incr_load = 1'b1; incr = 32'h4000_0000;
    @(negedge clk);
    incr_load = 1'b0;
    for (int i = 0; i < 8; i++) spaced_step("t1", exp1[i], 32'(i + 1) << 30, 3'd0, 1'b0);

    for (int i = 0; i < 8; i++) spaced_step("t2_gain", exp2[i], 32'(i + 1) << 30, 3'd1, 1'b0);

    incr_load = 1'b1; incr = 32'hC000_0000;
    @(negedge clk);
    incr_load = 1'b0;
    for (int i = 0; i < 4; i++) spaced_step("t3_wrap", exp3[i], ph3[i], 3'd0, 1'b0);

    incr_load = 1'b1; incr = 32'h4000_0000; sync = 1'b1;
    @(negedge clk);
    incr_load = 1'b0; sync = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step      = (i < 16);
      incr_load = (i == 7);
      incr      = 32'h8000_0000;
      if (i >= 3 && i < 19) begin
        chk("t4_valid", {31'b0, valid}, 32'd1);
        chk("t4_amp", {24'b0, amp}, {24'b0, exp4[i-3]});
      end else begin
        chk("t4_idle", {31'b0, valid}, 32'd0);
      end
      @(negedge clk);
    end
    step = 1'b0; incr_load = 1'b0;

    incr_load = 1'b1; incr = 32'h4000_0000;
    @(negedge clk);
    incr_load = 1'b0;
    for (int i = 0; i < 3; i++) spaced_step("t5", exp5[i], ph5[i], 3'd0, 1'b0);
    spaced_step("t5_syncstep", 8'sd2, 32'h4000_0000, 3'd0, 1'b1);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    chk("t5_sync_alone", phase, 32'd0);

    step = 1'b1;
    repeat (3) @(negedge clk);
    step = 1'b0;
    chk("t6_pre_valid", {31'b0, valid}, 32'd1);
    chk("t6_pre_amp", {24'b0, amp}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'b0, valid}, 32'd0);
    chk("t6_async_amp", {24'b0, amp}, 32'd0);
    chk("t6_async_phase", phase, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_no_stale", {31'b0, valid}, 32'd0);
    end
    spaced_step("t6_init_incr", 8'sd2, 32'h0962_FC96, 3'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
